// File: rtl/priority_pkg.sv
// Shared types for the priority decoder: FIFO occupancy states, code constants and the decode function.
package priority_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_L0   = 2'b01;
  localparam logic [1:0] CODE_L1   = 2'b10;
  localparam logic [1:0] CODE_L2   = 2'b11;

  function automatic logic [2:0] decode(input logic [1:0] code);
    logic [2:0] oneHot;
    oneHot = 3'b000;
    case (code)
      CODE_L0: oneHot = 3'b001;
      CODE_L1: oneHot = 3'b010;
      CODE_L2: oneHot = 3'b100;
      default: oneHot = 3'b000;
    endcase
    return oneHot;
  endfunction

endpackage

// File: rtl/pd_fifo2.sv
// Two-entry FIFO of decoded one-hot entries; data visible one cycle after push.
// Caller qualifies push/pop; a push is only honoured below FULL, a pop only above EMPTY.
module pd_fifo2
  import priority_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] din,
  output logic [2:0] dout,
  output occ_t       state
);

  occ_t       nextState;
  logic [2:0] mem0;
  logic [2:0] mem1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      EMPTY: if (push) nextState = ONE;
      ONE: begin
        if (push && !pop) nextState = FULL;
        else if (!push && pop) nextState = EMPTY;
      end
      FULL: if (pop) nextState = ONE;
      default: nextState = EMPTY;
    endcase
  end

  // mem0 always holds the oldest entry; mem1 only matters in FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem0 <= 3'b000;
      mem1 <= 3'b000;
    end else begin
      case (state)
        EMPTY: if (push) mem0 <= din;
        ONE: begin
          if (push && pop) mem0 <= din;
          else if (push) mem1 <= din;
        end
        FULL: if (pop) mem0 <= mem1;
        default: ;
      endcase
    end
  end

  assign dout = (state == EMPTY) ? 3'b000 : mem0;

endmodule

// File: rtl/priority_decoder.sv
// Decodes 2-bit priority codes to one-hot lines through a 2-entry buffer (1-cycle latency).
// in_ready drops only when the buffer is full; it never depends on out_ready.
module priority_decoder
  import priority_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_code,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2:0]       out_onehot,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] none_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  occ_t       fifoState;
  logic [2:0] fifoDout;
  logic       push;
  logic       pop;

  assign in_ready  = (fifoState != FULL);
  assign out_valid = (fifoState != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_onehot = fifoDout;

  pd_fifo2 uFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (decode(in_code)),
    .dout  (fifoDout),
    .state (fifoState)
  );

  // Count accepted "none" codes; hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      none_count <= '0;
    end else if (push && (in_code == CODE_NONE) && (none_count != CNT_MAX)) begin
      none_count <= none_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_priority_decoder.sv
// Directed and random stimulus against a queue-based model of the decoder.
module tb_priority_decoder;
  import priority_pkg::*;

  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       in_code;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       out_onehot;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] none_count;

  int checks = 0;
  int failures = 0;

  int expQ[$];
  int expCnt = 0;

  always #5 clk = ~clk;

  priority_decoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_code    (in_code),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_onehot (out_onehot),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .none_count (none_count)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 3-to-2 priority encoder used for the round-trip case
  function automatic logic [1:0] enc3(input logic [2:0] x);
    if (x[2]) return 2'b11;
    if (x[1]) return 2'b10;
    if (x[0]) return 2'b01;
    return 2'b00;
  endfunction

  task automatic compareAll();
    int expState;
    expState = expQ.size();
    check("out_valid", int'(out_valid), (expQ.size() > 0) ? 1 : 0);
    check("out_onehot", int'(out_onehot), (expQ.size() > 0) ? expQ[0] : 0);
    check("in_ready", int'(in_ready), (expQ.size() < 2) ? 1 : 0);
    check("none_count", int'(none_count), expCnt);
    check("state", int'(dut.uFifo.state), expState);
  endtask

  // Check outputs mid-cycle, drive inputs, and advance the model across the next edge.
  task automatic step(input logic v, input logic [1:0] c, input logic r);
    bit doPush, doPop;
    @(negedge clk);
    rst = 1'b0;
    compareAll();
    in_valid = v;
    in_code = c;
    out_ready = r;
    doPush = v && (expQ.size() < 2);
    doPop = r && (expQ.size() > 0);
    if (doPop) void'(expQ.pop_front());
    if (doPush) begin
      expQ.push_back((c == 2'b00) ? 0 : (1 << (int'(c) - 1)));
      if (c == 2'b00 && expCnt < CNT_MAX) expCnt++;
    end
    @(posedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_code = 2'b11;
    out_ready = 1'b1;
    expQ.delete();
    expCnt = 0;
    @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_code = 2'b00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    doReset();

    // sweep with downstream always ready
    step(1, 2'b01, 1);
    #1 check("sweep_l0", int'(out_onehot), 3'b001);
    step(1, 2'b10, 1);
    #1 check("sweep_l1", int'(out_onehot), 3'b010);
    step(1, 2'b11, 1);
    #1 check("sweep_l2", int'(out_onehot), 3'b100);
    step(1, 2'b00, 1);
    #1 check("sweep_none", int'(out_onehot), 3'b000);
    step(0, 2'b00, 1);

    // backpressure: fill, third code ignored, then drain in order
    step(1, 2'b11, 0);
    step(1, 2'b01, 0);
    step(1, 2'b10, 0);
    #1 check("bp_full_ready", int'(in_ready), 0);
    step(0, 2'b00, 0);
    step(0, 2'b00, 1);
    #1 check("bp_second", int'(out_onehot), 3'b001);
    step(0, 2'b00, 1);

    // simultaneous push and pop while holding one entry
    step(1, 2'b10, 0);
    step(1, 2'b11, 1);
    step(1, 2'b01, 1);
    #1 check("simul_one", int'(dut.uFifo.state), int'(ONE));
    step(0, 2'b00, 1);

    // saturation of the none counter
    for (int i = 0; i < 260; i++) step(1, 2'b00, 1);
    step(0, 2'b00, 1);
    #1 check("sat_count", int'(none_count), CNT_MAX);

    // reset while full
    step(1, 2'b11, 0);
    step(1, 2'b10, 0);
    doReset();
    #1 check("rst_valid", int'(out_valid), 0);
    check("rst_count", int'(none_count), 0);
    check("rst_ready", int'(in_ready), 1);
    step(1, 2'b10, 0);
    step(0, 2'b00, 1);

    // round trip through a priority encoder
    step(1, enc3(3'b110), 1);
    #1 check("rt_110", int'(out_onehot), 3'b100);
    step(1, enc3(3'b011), 1);
    #1 check("rt_011", int'(out_onehot), 3'b010);
    step(0, 2'b00, 1);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) doReset();
      else step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    step(0, 2'b00, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priority_decoder.md
PRIORITY_DECODER -- requirements
Module: priority_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the none-code counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset, synchronous to clk, active-high.
REQ-004 SHALL have port in_code  input  2  encoded priority code (2'b11 = line 2, 2'b10 = line 1, 2'b01 = line 0, 2'b00 = none).
REQ-005 SHALL have port in_valid  input  1  in_code is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block can accept a code this cycle.
REQ-007 SHALL have port out_onehot  output  3  decoded one-hot request lines (all zero for code 2'b00).
REQ-008 SHALL have port out_valid  output  1  out_onehot holds a decoded entry.
REQ-009 SHALL have port out_ready  input  1  downstream consumes the entry this cycle.
REQ-010 SHALL have port none_count  output  CNT_W  saturating count of accepted 2'b00 codes.

Function
REQ-011 SHALL decode 2'b01 -> 3'b001, 2'b10 -> 3'b010, 2'b11 -> 3'b100, 2'b00 -> 3'b000.
REQ-012 SHALL accept (push) on a cycle where in_valid && in_ready, and pop on a cycle where out_valid && out_ready.
REQ-013 SHALL buffer decoded entries in a 2-entry FIFO with occupancy states EMPTY, ONE, FULL.
REQ-014 SHALL make these state transitions:
- EMPTY: push -> ONE.
- ONE: push only -> FULL; pop only -> EMPTY; push and pop in the same cycle -> ONE.
- FULL: pop -> ONE.
- Otherwise the state holds.
REQ-015 SHALL drive in_ready = (state != FULL), combinationally from registered state only (no dependence on out_ready).
REQ-016 SHALL drive out_valid = (state != EMPTY) and out_onehot from the oldest entry; out_onehot = 3'b000 when EMPTY.
REQ-017 SHALL have latency one cycle: a code accepted at edge N produces out_valid high in the cycle after edge N, even if out_ready is already high.
REQ-018 SHALL hold out_onehot and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL preserve acceptance order; entries are never dropped or duplicated.
REQ-020 SHALL ignore in_code when in_valid is low, or when in_valid is high in FULL state (no push).
REQ-021 SHALL increment none_count by 1 on each accepted 2'b00 code and saturate at 2^CNT_W-1 (no wrap).
REQ-022 SHALL treat a 2'b00 code as a normal entry (pushed and popped) in addition to counting it.

Reset
REQ-023 SHALL, while rst is high at posedge clk, set state = EMPTY, both FIFO entries = 3'b000, none_count = 0, out_valid = 0, out_onehot = 3'b000, in_ready = 1 from the following cycle.
REQ-024 SHALL give rst priority over a simultaneous push or pop; an assertion mid-operation discards all buffered entries.
REQ-025 SHALL accept a push on the first cycle after rst deasserts.

Structure
REQ-026 SHALL place the occupancy-state enum (EMPTY/ONE/FULL), code constants (CODE_NONE/CODE_L0/CODE_L1/CODE_L2) and the decode function in shared package priority_pkg.
REQ-027 SHALL implement the 2-entry buffer as sub-module pd_fifo2 (clk, rst, push, pop, din[2:0], dout[2:0], state); decode and counter logic stay in priority_decoder.

Verification
REQ-028 SHALL cover a sweep: codes 01, 10, 11, 00 with out_ready=1 -> 001, 010, 100, 000 in order, each one cycle after acceptance.
REQ-029 SHALL cover backpressure: out_ready=0, push 11 then 01 -> state FULL, in_ready=0, a third code 10 ignored; out_ready=1 -> 100 then 001.
REQ-030 SHALL cover simultaneous events: in ONE state, push and pop in the same cycle -> state stays ONE with the correct order.
REQ-031 SHALL cover saturation: 260 accepted 2'b00 codes with CNT_W=8 -> none_count=255.
REQ-032 SHALL cover reset mid-operation: state FULL, rst high for one cycle -> out_valid=0, none_count=0, in_ready=1.
REQ-033 SHALL cover a round trip: a 3-to-2 priority encoder feeding priority_decoder with inputs 3'b110 -> out_onehot 3'b100; 3'b011 -> 3'b010.
